serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_pkg.sv | 24 ++
 rtl/serial_add_seq_fa_cell.sv | 34 +++
 rtl/serial_add_seq.sv | 126 ++++++++++++
 tb/tb_serial_add_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the bit-serial adder:
//     - state_e       : controller states (IDLE, RUN, DONE)
//     - DEFAULT_WIDTH : default operand width in bits
//     - cnt_width()   : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bit positions 0..width-1, i.e. ceil(log2(width)) bits.
  // The guard keeps the counter at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// ----------------------------------------------------------------------------
// fa_cell
//   Combinational 1-bit full adder built from two half-adder stages whose
//   carries are merged by an OR.
//   Ports:
//     x, y : operand bits
//     cin  : carry in
//     s    : sum bit
//     co   : carry out
// ----------------------------------------------------------------------------
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: x + y
  assign ha0_s = x ^ y;
  assign ha0_c = x & y;

  // Second half adder: partial sum + carry in
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  // At most one of the two stage carries can be set
  assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_seq.sv
// ----------------------------------------------------------------------------
// serial_add_seq
//   Bit-serial adder: computes a + b LSB first through a single shared
//   full-adder cell, one bit per clock. An addition takes WIDTH RUN cycles
//   followed by a one-cycle DONE state.
//   Parameters:
//     WIDTH : operand width in bits (legal range 2..32)
//   Ports:
//     clk   : clock, rising edge
//     rst   : synchronous active-high reset
//     start : begin an addition (sampled only while ready)
//     a, b  : operands, captured on the accept cycle
//     ready : high in IDLE
//     busy  : high in RUN
//     done  : one-cycle pulse in DONE
//     sum   : a + b mod 2^WIDTH (valid from DONE until the next accept)
//     cout  : carry out of the MSB
// ----------------------------------------------------------------------------
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] op_a_d;
  logic [WIDTH-1:0] op_b_d;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;

  logic cell_s;
  logic cell_co;

  // The one adder cell: always looks at the current LSBs and the stored carry
  fa_cell u_fa_cell (
    .x   (op_a_q[0]),
    .y   (op_b_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .co  (cell_co)
  );

  // Shift values for one RUN step. The sum bit enters at the MSB so that
  // after WIDTH steps the first (LSB) result bit has reached bit 0.
  always_comb begin
    op_a_d = {1'b0, op_a_q[WIDTH-1:1]};
    op_b_d = {1'b0, op_b_q[WIDTH-1:1]};
    sum_d  = {cell_s, sum_q[WIDTH-1:1]};
    cnt_d  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // sum/cout are left alone so the last result stays visible
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end

        RUN: begin
          op_a_q  <= op_a_d;
          op_b_q  <= op_b_d;
          sum_q   <= sum_d;
          carry_q <= cell_co;
          cnt_q   <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            // Final bit: publish the carry out together with the full sum
            cout_q  <= cell_co;
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags come straight from the state register
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// ----------------------------------------------------------------------------
// tb_serial_add_seq
//   Self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=16.
// ----------------------------------------------------------------------------
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, ready8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, ready16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        co;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, carry lands at bit w
  function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return ({1'b0, x} & m) + ({1'b0, y} & m);
  endfunction

  task automatic drive(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
    if (w == 8) begin
      start8 = s; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start16 = s; a16 = x[15:0]; b16 = y[15:0];
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 8) ? ready8 : ready16;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic [32:0] get_res(input int w);
    return (w == 8) ? {24'd0, cout8, sum8} : {16'd0, cout16, sum16};
  endfunction

  // Performs one addition. lat = clock edges from the accept edge
  // (inclusive) until done is seen; nbusy = cycles with busy high.
  // Operands are scrambled right after the accept edge.
  task automatic do_op(input int w, input logic [31:0] x, input logic [31:0] y,
                       output logic [32:0] res, output int lat, output int nbusy);
    int guard;
    guard = 0;
    while (!get_ready(w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    drive(w, 1'b1, x, y);
    @(negedge clk);
    drive(w, 1'b0, $urandom, $urandom);
    lat   = 1;
    nbusy = 0;
    while (!get_done(w) && lat < 100) begin
      if (get_busy(w)) nbusy++;
      @(negedge clk);
      lat++;
    end
    res = get_res(w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] res;
    logic [32:0] exp;
    int          lat;
    int          nbusy;
    int          guard;
    int          ndone;
    int          last_done;
    int          prev_done;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{8,  32'h5A,   32'h3C,   32'h96,   1'b0};
    vecs[1] = '{8,  32'hFF,   32'h01,   32'h00,   1'b1};
    vecs[2] = '{8,  32'hFF,   32'hFF,   32'hFE,   1'b1};
    vecs[3] = '{8,  32'h80,   32'h80,   32'h00,   1'b1};
    vecs[4] = '{8,  32'h00,   32'h00,   32'h00,   1'b0};
    vecs[5] = '{8,  32'h7F,   32'h01,   32'h80,   1'b0};
    vecs[6] = '{16, 32'hFFFF, 32'h0001, 32'h0000, 1'b1};
    vecs[7] = '{16, 32'h1234, 32'h4321, 32'h5555, 1'b0};

    // ---------------- reset, start already requested ----------------
    rst = 1'b1;
    drive(8, 1'b1, 32'h0F, 32'h01);
    drive(16, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready8", 64'(ready8), 64'd1);
    check("rst_busy8",  64'(busy8),  64'd0);
    check("rst_done8",  64'(done8),  64'd0);
    check("rst_sum8",   64'(sum8),   64'd0);
    check("rst_cout8",  64'(cout8),  64'd0);
    check("rst_ready16", 64'(ready16), 64'd1);
    check("rst_sum16",  64'(sum16),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    drive(8, 1'b0, 32'h0, 32'h0);
    check("first_accept_busy", 64'(busy8), 64'd1);
    lat = 1;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("first_accept_lat", 64'(lat), 64'd9);
    check("first_accept_res", 64'(get_res(8)), 64'(33'h010));
    $display("[TB] after-reset op 0x0F+0x01 -> cout=%0d sum=0x%0h lat=%0d", cout8, sum8, lat);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].w, vecs[i].a, vecs[i].b, res, lat, nbusy);
      exp = 33'(vecs[i].sum) | (33'(vecs[i].co) << vecs[i].w);
      $display("[TB] vec %0d w=%0d a=0x%0h b=0x%0h -> res=0x%0h lat=%0d",
               i, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_res", i), 64'(res), 64'(exp));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].w + 1));
      check($sformatf("vec%0d_busy", i), 64'(nbusy), 64'(vecs[i].w));
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), 64'(get_ready(vecs[i].w)), 64'd1);
      check($sformatf("vec%0d_done_1cyc", i), 64'(get_done(vecs[i].w)), 64'd0);
    end

    // ---------------- start during RUN is ignored ----------------
    drive(8, 1'b1, 32'h5A, 32'h3C);
    @(negedge clk);
    drive(8, 1'b0, 32'h0, 32'h0);
    lat = 1;
    nbusy = 0;
    while (!done8 && lat < 100) begin
      if (busy8) nbusy++;
      if (lat == 3) drive(8, 1'b1, 32'h11, 32'h22);
      else          drive(8, 1'b0, 32'h11, 32'h22);
      @(negedge clk);
      lat++;
    end
    drive(8, 1'b0, 32'h0, 32'h0);
    $display("[TB] ignored-start op 0x5A+0x3C -> cout=%0d sum=0x%0h lat=%0d busy=%0d", cout8, sum8, lat, nbusy);
    check("ign_res", 64'(get_res(8)), 64'(33'h096));
    check("ign_lat", 64'(lat), 64'd9);
    check("ign_busy_cycles", 64'(nbusy), 64'd8);
    @(negedge clk);
    check("ign_ready", 64'(ready8), 64'd1);
    @(negedge clk);
    check("ign_not_queued", 64'(busy8), 64'd0);
    check("ign_hold_sum", 64'(get_res(8)), 64'(33'h096));

    // ---------------- reset at RUN cycle 4 ----------------
    drive(8, 1'b1, 32'hFF, 32'hFF);
    @(negedge clk);
    drive(8, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 64'(ready8), 64'd1);
    check("abort_busy",  64'(busy8),  64'd0);
    check("abort_sum",   64'(sum8),   64'd0);
    check("abort_cout",  64'(cout8),  64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    $display("[TB] aborted op 0xFF+0xFF -> done pulses=%0d", ndone);

    // ---------------- back-to-back with start held ----------------
    drive(8, 1'b1, 32'h80, 32'h80);
    ndone = 0;
    prev_done = -1;
    for (int c = 0; c < 45; c++) begin
      if (done8) begin
        ndone++;
        $display("[TB] b2b done at cycle %0d -> cout=%0d sum=0x%0h", c, cout8, sum8);
        check("b2b_res", 64'(get_res(8)), 64'(33'h100));
        if (prev_done >= 0) check("b2b_interval", 64'(c - prev_done), 64'd10);
        prev_done = c;
      end
      @(negedge clk);
    end
    last_done = ndone;
    check("b2b_count", 64'(last_done >= 4), 64'd1);
    drive(8, 1'b0, 32'h0, 32'h0);
    guard = 0;
    while (!ready8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end

    // ---------------- randomized, both widths ----------------
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 8 : 16;
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom & ((32'd1 << w) - 32'd1);
        rb = $urandom & ((32'd1 << w) - 32'd1);
        do_op(w, ra, rb, res, lat, nbusy);
        exp = model(w, ra, rb);
        $display("[TB] rand w=%0d a=0x%0h b=0x%0h -> res=0x%0h lat=%0d", w, ra, rb, res, lat);
        check($sformatf("rand%0d_res", w), 64'(res), 64'(exp));
        check($sformatf("rand%0d_lat", w), 64'(lat), 64'(w + 1));
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
